// File: rtl/execute.sv
// Execute stage of the in-order RV32 pipeline.
// Computes one 32-bit result per instruction (ALU value, effective address or
// link address) plus branch resolution, and registers it toward memory access.
// Optional macro RV32M_EN builds an iterative 32-step multiply/divide unit that
// stalls upstream while it works; without it M ops issue as result 0.
module execute #(
    parameter int unsigned XLEN = 32,
    parameter logic [31:0] NOP  = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic            branch_taken_o,
    output logic [XLEN-1:0] branch_target_o
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_b, alu_out, result_c, target_c, issue_result;
    logic        taken_c, br_cond, is_m_op, stall_c;

    assign opcode  = instr_i[6:0];
    assign funct3  = instr_i[14:12];
    assign is_m_op = (opcode == OpReg) && (instr_i[31:25] == 7'b0000001);

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

    assign op_b = (opcode == OpReg) ? rs2_data_i : imm_i;

    // Integer ALU shared by OP and OP-IMM; instr[30] selects SUB (OP only) and SRA
    always_comb begin
        alu_out = '0;
        case (funct3)
            3'b000: alu_out = ((opcode == OpReg) && instr_i[30]) ? rs1_data_i - op_b
                                                                  : rs1_data_i + op_b;
            3'b001: alu_out = rs1_data_i << op_b[4:0];
            3'b010: alu_out = {31'b0, $signed(rs1_data_i) < $signed(op_b)};
            3'b011: alu_out = {31'b0, rs1_data_i < op_b};
            3'b100: alu_out = rs1_data_i ^ op_b;
            3'b101: alu_out = instr_i[30] ? $unsigned($signed(rs1_data_i) >>> op_b[4:0])
                                          : rs1_data_i >> op_b[4:0];
            3'b110: alu_out = rs1_data_i | op_b;
            default: alu_out = rs1_data_i & op_b;
        endcase
    end

    // Branch compare outcome
    always_comb begin
        case (funct3)
            3'b000:  br_cond = (rs1_data_i == rs2_data_i);
            3'b001:  br_cond = (rs1_data_i != rs2_data_i);
            3'b100:  br_cond = ($signed(rs1_data_i) < $signed(rs2_data_i));
            3'b101:  br_cond = ($signed(rs1_data_i) >= $signed(rs2_data_i));
            3'b110:  br_cond = (rs1_data_i < rs2_data_i);
            3'b111:  br_cond = (rs1_data_i >= rs2_data_i);
            default: br_cond = 1'b0;
        endcase
    end

    // Per-opcode result, taken flag and redirect target
    always_comb begin
        result_c = '0;
        taken_c  = 1'b0;
        target_c = '0;
        case (opcode)
            OpLui:    result_c = imm_u;
            OpAuipc:  result_c = pc_i + imm_u;
            OpJal: begin
                result_c = pc_i + 32'd4;
                taken_c  = 1'b1;
                target_c = pc_i + imm_j;
            end
            OpJalr: begin
                result_c = pc_i + 32'd4;
                taken_c  = 1'b1;
                target_c = (rs1_data_i + imm_i) & ~32'h1;
            end
            OpBranch: begin
                taken_c  = br_cond;
                target_c = pc_i + imm_b;
            end
            OpLoad:   result_c = rs1_data_i + imm_i;
            OpStore:  result_c = rs1_data_i + imm_s;
            OpImm:    result_c = alu_out;
            OpReg:    result_c = is_m_op ? 32'd0 : alu_out;
            default:  ;
        endcase
    end

`ifdef RV32M_EN
    typedef enum logic [1:0] {StIdle, StBusy, StDone} m_state_e;

    m_state_e    state_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;     // multiply: {partial high, multiplier}; divide: {rem, quo}
    logic [31:0] opb_q;     // multiplicand or divisor magnitude
    logic        m_div, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, m_result;
    logic [32:0] mul_sum, div_shift;
    logic [31:0] div_diff;
    logic [63:0] mul_next, div_next, prod;
    logic [31:0] quo_fix, rem_fix;

    assign m_div = funct3[2];
    assign a_neg = rs1_data_i[31] && (m_div ? !funct3[0] : (funct3[1:0] != 2'b11));
    assign b_neg = rs2_data_i[31] && (m_div ? !funct3[0] : !funct3[1]);
    assign a_mag = a_neg ? -rs1_data_i : rs1_data_i;
    assign b_mag = b_neg ? -rs2_data_i : rs2_data_i;

    // One shift-add or restoring-subtract step per BUSY cycle
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift[31:0] - opb_q;
        div_next  = (div_shift >= {1'b0, opb_q}) ? {div_diff, acc_q[30:0], 1'b1}
                                                 : {div_shift[31:0], acc_q[30:0], 1'b0};
    end

    // Sign fix and result select, valid in DONE while upstream holds the operands
    always_comb begin
        prod    = (a_neg ^ b_neg) ? -acc_q : acc_q;
        quo_fix = (a_neg ^ b_neg) ? -acc_q[31:0] : acc_q[31:0];
        rem_fix = a_neg ? -acc_q[63:32] : acc_q[63:32];
        if (rs2_data_i == 32'd0) begin
            quo_fix = 32'hFFFF_FFFF;
            rem_fix = rs1_data_i;
        end
        if (m_div)             m_result = funct3[1] ? rem_fix : quo_fix;
        else if (funct3 == 3'b000) m_result = prod[31:0];
        else                   m_result = prod[63:32];
    end

    assign stall_c = !flush_i && (((state_q == StIdle) && valid_i && is_m_op)
                                  || (state_q == StBusy));

    // M unit FSM and iterative datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
        end else if (flush_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (valid_i && is_m_op) begin
                        acc_q   <= {32'd0, a_mag};
                        opb_q   <= b_mag;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    acc_q <= m_div ? div_next : mul_next;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign issue_result = is_m_op ? m_result : result_c;
`else
    assign stall_c      = 1'b0;
    assign issue_result = result_c;
`endif

    assign stall_o = stall_c;

    // Pipeline register toward memory access; flush and stalls issue a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o         <= 1'b0;
            instr_o         <= NOP;
            alu_result_o    <= '0;
            branch_taken_o  <= 1'b0;
            branch_target_o <= '0;
        end else if (!flush_i && !stall_c && valid_i) begin
            valid_o         <= 1'b1;
            instr_o         <= instr_i;
            alu_result_o    <= issue_result;
            branch_taken_o  <= taken_c;
            branch_target_o <= target_c;
        end else begin
            valid_o         <= 1'b0;
            instr_o         <= NOP;
            alu_result_o    <= '0;
            branch_taken_o  <= 1'b0;
            branch_target_o <= '0;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage; M-unit vectors run when RV32M_EN is defined.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] instr_i = 32'h0000_0013;
    logic [31:0] pc_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o, valid_o, branch_taken_o;
    logic [31:0] instr_o, alu_result_o, branch_target_o;

    int n_checks = 0;
    int n_fail   = 0;

    execute dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid_i),
        .instr_i         (instr_i),
        .pc_i            (pc_i),
        .rs1_data_i      (rs1_data_i),
        .rs2_data_i      (rs2_data_i),
        .flush_i         (flush_i),
        .stall_o         (stall_o),
        .valid_o         (valid_o),
        .instr_o         (instr_o),
        .alu_result_o    (alu_result_o),
        .branch_taken_o  (branch_taken_o),
        .branch_target_o (branch_target_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        valid_i    = 1'b1;
        instr_i    = ins;
        pc_i       = pc;
        rs1_data_i = a;
        rs2_data_i = b;
    endtask

`ifdef RV32M_EN
    // Issue an M op, count stall cycles, and check the final result
    task automatic run_m(input string tag, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int stalls;
        drive(ins, 32'h0, a, b);
        #1;
        stalls = 0;
        while (stall_o && stalls < 40) begin
            tick();
            stalls++;
        end
        check({tag, " stall cycles"}, stalls, 32'd33);
        check({tag, " bubble while stalled"}, {31'b0, valid_o}, 32'd0);
        tick();
        check({tag, " result"}, alu_result_o, exp);
        check({tag, " valid"}, {31'b0, valid_o}, 32'd1);
    endtask
`endif

    initial begin
        // Reset with an ADDI x1,x0,-1 already presented
        drive(32'hFFF0_0093, 32'h0, 32'h0, 32'h0);
        #12;
        check("reset instr_o", instr_o, 32'h0000_0013);
        check("reset valid_o", {31'b0, valid_o}, 32'd0);
        check("reset result", alu_result_o, 32'd0);
        check("reset taken", {31'b0, branch_taken_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("addi result", alu_result_o, 32'hFFFF_FFFF);
        check("addi valid", {31'b0, valid_o}, 32'd1);
        check("addi instr_o", instr_o, 32'hFFF0_0093);

        // SUB then SRA, back to back
        drive(32'h4020_81B3, 32'h0, 32'h8000_0000, 32'd4);
        #1;
        check("sub stall", {31'b0, stall_o}, 32'd0);
        tick();
        check("sub result", alu_result_o, 32'h7FFF_FFFC);
        drive(32'h4020_D1B3, 32'h0, 32'h8000_0000, 32'd4);
        #1;
        check("sra stall", {31'b0, stall_o}, 32'd0);
        tick();
        check("sra result", alu_result_o, 32'hF800_0000);
        check("sra valid", {31'b0, valid_o}, 32'd1);

        // BLT -1 < 1 taken, offset -8
        drive(32'hFE20_CCE3, 32'h100, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("blt taken", {31'b0, branch_taken_o}, 32'd1);
        check("blt target", branch_target_o, 32'h0000_00F8);
        check("blt result", alu_result_o, 32'd0);

        // BEQ 1 == 2 not taken, offset +8
        drive(32'h0020_8463, 32'h200, 32'd1, 32'd2);
        tick();
        check("beq taken", {31'b0, branch_taken_o}, 32'd0);
        check("beq target", branch_target_o, 32'h0000_0208);

        // JALR x1,0(x5)
        drive(32'h0002_80E7, 32'h400, 32'h203, 32'h0);
        tick();
        check("jalr taken", {31'b0, branch_taken_o}, 32'd1);
        check("jalr target", branch_target_o, 32'h0000_0202);
        check("jalr result", alu_result_o, 32'h0000_0404);

        // LUI and LW address
        drive(32'h1234_50B7, 32'h0, 32'h0, 32'h0);
        tick();
        check("lui result", alu_result_o, 32'h1234_5000);
        drive(32'h0081_2083, 32'h0, 32'h1000, 32'h0);
        tick();
        check("lw address", alu_result_o, 32'h0000_1008);

        // Idle cycle issues a bubble
        valid_i = 1'b0;
        tick();
        check("idle valid", {31'b0, valid_o}, 32'd0);
        check("idle instr_o", instr_o, 32'h0000_0013);

        // Flush kills a single-cycle op
        drive(32'h0020_81B3, 32'h0, 32'd5, 32'd6);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush add valid", {31'b0, valid_o}, 32'd0);
        check("flush add result", alu_result_o, 32'd0);

`ifdef RV32M_EN
        run_m("mulh", 32'h0220_91B3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_m("div by zero", 32'h0220_C1B3, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_m("rem overflow", 32'h0220_E1B3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_m("div overflow", 32'h0220_C1B3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_m("divu", 32'h0220_D1B3, 32'd100, 32'd7, 32'd14);
        run_m("mul neg", 32'h0220_81B3, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);

        // Flush DIVU at BUSY cycle 10
        drive(32'h0220_D1B3, 32'h0, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        check("divu busy stall", {31'b0, stall_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        check("flush drops stall", {31'b0, stall_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        check("flush bubble valid", {31'b0, valid_o}, 32'd0);
        check("flush bubble instr", instr_o, 32'h0000_0013);
        drive(32'h0020_81B3, 32'h0, 32'd5, 32'd6);
        #1;
        check("add after flush stall", {31'b0, stall_o}, 32'd0);
        tick();
        check("add after flush result", alu_result_o, 32'd11);
        check("add after flush valid", {31'b0, valid_o}, 32'd1);
`else
        // Without the M unit, MUL issues in one cycle with result 0
        drive(32'h0220_81B3, 32'h0, 32'd3, 32'd5);
        #1;
        check("mul stall", {31'b0, stall_o}, 32'd0);
        tick();
        check("mul result", alu_result_o, 32'd0);
        check("mul valid", {31'b0, valid_o}, 32'd1);
        check("mul instr_o", instr_o, 32'h0220_81B3);
`endif

        valid_i = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
